codec_reg_cmd_queue: RTL

- Upstream neighbour of the codec controller unit; accepts CODEC register read/write commands from the processor-side register block.
- Buffers commands in a small FIFO and replays them one at a time onto the controller's codec_rd_en/codec_wr_en interface, honouring controller_busy.
- Returns one response per command: read data, or write completion, with error status for missed ACK or timeout.
- Removes the need for software to poll busy between register accesses.

---
 rtl/codec_cmd_pkg.sv | 23 ++
 rtl/codec_cmd_fifo.sv | 59 +++++
 rtl/codec_reg_cmd_queue.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/codec_cmd_pkg.sv
// Shared types for the CODEC register command queue: FSM states, response codes, FIFO entry.
package codec_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESP
  } cmd_state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_NACK     = 2'd1;
  localparam logic [1:0] ERR_START_TO = 2'd2;
  localparam logic [1:0] ERR_DONE_TO  = 2'd3;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [8:0] wdata;
  } codec_cmd_t;

endpackage

// File: rtl/codec_cmd_fifo.sv
// Single-clock FIFO, head visible combinationally; one cycle push-to-head.
// Push ignored while full, pop ignored while empty; full is a registered flag.
module codec_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  T              push_dat_i,
  input  logic          pop_i,
  output T              head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && (level_q != '0);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/codec_reg_cmd_queue.sv
// Queues CODEC register commands and replays them one at a time to the controller, one response each.
// Issue pulse 2 cycles after a command reaches the FIFO head; next issue waits for the response to be consumed.
module codec_reg_cmd_queue
  import codec_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int START_WINDOW   = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [7:0]                    cmd_addr,
  input  logic [8:0]                    cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [7:0]                    rsp_addr,
  output logic [8:0]                    rsp_rdata,
  output logic [1:0]                    rsp_error,
  output logic                          codec_rd_en,
  output logic                          codec_wr_en,
  output logic [7:0]                    codec_reg_addr,
  output logic [8:0]                    codec_data_in,
  input  logic [8:0]                    codec_data_out,
  input  logic                          codec_data_out_valid,
  input  logic                          controller_busy,
  input  logic                          missed_ack,
  output logic [$clog2(FIFO_DEPTH):0]   queue_level
);

  localparam int CNT_W = 1 + $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_WINDOW);
  localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(TIMEOUT_CYCLES);

  cmd_state_t       state_q;
  codec_cmd_t       push_cmd, head_cmd;
  logic             fifo_full, fifo_empty, pop_go;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nack_q, cur_write_q;
  logic             rsp_valid_q, rsp_write_q, rd_en_q, wr_en_q;
  logic [7:0]       rsp_addr_q, reg_addr_q;
  logic [8:0]       rsp_rdata_q, data_in_q;
  logic [1:0]       rsp_error_q;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  codec_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (codec_cmd_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (cmd_valid),
    .push_dat_i (push_cmd),
    .pop_i      (pop_go),
    .head_o     (head_cmd),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (queue_level)
  );

  assign pop_go = (state_q == IDLE) && !fifo_empty && !controller_busy && !rsp_valid_q;
  assign cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nack_q      <= 1'b0;
      cur_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= ERR_OK;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      reg_addr_q  <= '0;
      data_in_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: if (pop_go) begin
          reg_addr_q  <= head_cmd.addr;
          data_in_q   <= head_cmd.wdata;
          cur_write_q <= head_cmd.write;
          state_q     <= ISSUE;
        end
        ISSUE: begin
          wr_en_q     <= cur_write_q;
          rd_en_q     <= !cur_write_q;
          cnt_q       <= '0;
          nack_q      <= 1'b0;
          rsp_write_q <= cur_write_q;
          rsp_addr_q  <= reg_addr_q;
          rsp_rdata_q <= '0;
          rsp_error_q <= ERR_OK;
          state_q     <= WAIT_START;
        end
        WAIT_START: begin
          cnt_q <= cnt_d;
          if (controller_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_d == START_LIM) begin
            rsp_error_q <= ERR_START_TO;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WAIT_DONE: begin
          cnt_q <= cnt_d;
          if (codec_data_out_valid && !rsp_write_q) rsp_rdata_q <= codec_data_out;
          if (missed_ack) nack_q <= 1'b1;
          // Busy was high on entry, so the first low sample is its falling edge.
          if (!controller_busy) begin
            rsp_error_q <= (nack_q || missed_ack) ? ERR_NACK : ERR_OK;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_d == DONE_LIM) begin
            rsp_error_q <= ERR_DONE_TO;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = !fifo_full;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_addr       = rsp_addr_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign codec_rd_en    = rd_en_q;
  assign codec_wr_en    = wr_en_q;
  assign codec_reg_addr = reg_addr_q;
  assign codec_data_in  = data_in_q;

endmodule
